// File: rtl/pim_microprog_queue.sv
// Microprogram load queue: buffers whole programs from the host handshake and unpacks them word by word.
// Optional build macro PIM_MP_ZERO_SKIP_EN: silently skip all-zero command words.
module pim_microprog_queue #(
  parameter int unsigned CMD_BITS   = 64,
  parameter int unsigned PROG_WORDS = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           mp_valid,
  input  logic [CMD_BITS*PROG_WORDS-1:0] mp_data,
  output logic                           mp_ack,
  output logic                           cmd_valid,
  output logic [CMD_BITS-1:0]            cmd_data,
  output logic                           cmd_last,
  input  logic                           cmd_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(PROG_WORDS);
  localparam int unsigned PB = CMD_BITS * PROG_WORDS;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t          r_state;
  logic [PB-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_count;
  logic            r_armed;
  logic            r_mp_ack;
  logic            r_full;
  logic            r_empty;

  logic [PB-1:0]       w_head;
  logic [CMD_BITS-1:0] w_words [PROG_WORDS];
  logic [CMD_BITS-1:0] w_word;
  logic                w_emit;
  logic                w_idx_last;
  logic                w_cmd_valid;
  logic                w_cmd_last;
  logic                w_skip;
  logic                w_adv;
  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_count_nxt;

  // Split the head entry into its command words
  assign w_head = r_mem[r_rd_ptr];
  for (genvar g = 0; g < PROG_WORDS; g++) begin : g_words
    assign w_words[g] = w_head[g*CMD_BITS +: CMD_BITS];
  end

  assign w_word     = w_words[r_idx];
  assign w_emit     = (r_state == S_EMIT);
  assign w_idx_last = (r_idx == IW'(PROG_WORDS - 1));

`ifdef PIM_MP_ZERO_SKIP_EN
  logic w_word_zero;
  logic w_later_nz;

  // A non-zero word is last when every higher-indexed word of the entry is zero
  always_comb begin
    w_later_nz = 1'b0;
    for (int i = 0; i < PROG_WORDS; i++) begin
      if ((IW'(i) > r_idx) && (w_words[i] != '0)) w_later_nz = 1'b1;
    end
  end

  assign w_word_zero = (w_word == '0);
  assign w_cmd_valid = w_emit & ~w_word_zero;
  assign w_cmd_last  = ~w_later_nz;
  assign w_skip      = w_emit & w_word_zero;
`else
  assign w_cmd_valid = w_emit;
  assign w_cmd_last  = w_idx_last;
  assign w_skip      = 1'b0;
`endif

  assign w_adv  = (w_cmd_valid & cmd_ready) | w_skip;
  assign w_pop  = w_adv & w_idx_last;
  // Registered full: a same-cycle pop never makes room for a push
  assign w_push = mp_valid & r_armed & ~r_full & ~flush;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_idx    <= '0;
      r_count  <= '0;
      r_armed  <= 1'b1;
      r_mp_ack <= 1'b0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_mp_ack <= w_push;
      if (!mp_valid)   r_armed <= 1'b1;
      else if (w_push) r_armed <= 1'b0;

      if (flush) begin
        r_state  <= S_IDLE;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_idx    <= '0;
        r_count  <= '0;
        r_full   <= 1'b0;
        r_empty  <= 1'b1;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_adv)  r_idx    <= w_idx_last ? '0 : r_idx + IW'(1);
        r_count <= w_count_nxt;
        r_full  <= (w_count_nxt == CW'(DEPTH));
        r_empty <= (w_count_nxt == '0);
        r_state <= (w_count_nxt != '0) ? S_EMIT : S_IDLE;
      end
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= mp_data;
  end

  assign mp_ack    = r_mp_ack;
  assign cmd_valid = w_cmd_valid;
  assign cmd_data  = w_word;
  assign cmd_last  = w_cmd_valid & w_cmd_last;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;

endmodule

// File: tb/tb_pim_microprog_queue.sv
// Directed bench for pim_microprog_queue: vector table plus multi-cycle sequences with an expected-word queue.
module tb_pim_microprog_queue;

  localparam int unsigned CB  = 64;
  localparam int unsigned PWD = 4;
  localparam int unsigned DP  = 4;
  localparam int unsigned PB  = CB * PWD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          mp_valid = 1'b0;
  logic [PB-1:0] mp_data = '0;
  logic          mp_ack;
  logic          cmd_valid;
  logic [CB-1:0] cmd_data;
  logic          cmd_last;
  logic          cmd_ready = 1'b0;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  pim_microprog_queue #(.CMD_BITS(CB), .PROG_WORDS(PWD), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mp_valid(mp_valid), .mp_data(mp_data),
    .mp_ack(mp_ack), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_last(cmd_last),
    .cmd_ready(cmd_ready), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, flush, mv;
    logic [PB-1:0] md;
    logic rdy;
    logic ack, vld;
    logic [CB-1:0] dat;
    logic last;
    logic [2:0] cnt;
    logic fl, em;
  } vec_t;

  typedef struct { logic [CB-1:0] d; logic l; } wexp_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    n_xfer = 0;
  wexp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [CB-1:0] mkw(input logic [7:0] op, input logic [31:0] addr,
                                        input logic [15:0] n);
    return {op, 8'h00, addr, n};
  endfunction

  function automatic logic [PB-1:0] prog(input int k);
    logic [PB-1:0] p;
    for (int j = 0; j < PWD; j++)
      p[j*CB +: CB] = mkw(8'(8'h10 + k), 32'(k * 256 + j), 16'(j + 1));
    return p;
  endfunction

  function automatic logic [CB-1:0] word_of(input logic [PB-1:0] p, input int j);
    return p[j*CB +: CB];
  endfunction

  function automatic vec_t mkv(input logic r, input logic f, input logic mv, input logic [PB-1:0] md,
                               input logic rdy, input logic ack, input logic vld,
                               input logic [CB-1:0] dat, input logic last, input logic [2:0] cnt,
                               input logic fl, input logic em);
    vec_t v;
    v.rst = r; v.flush = f; v.mv = mv; v.md = md; v.rdy = rdy;
    v.ack = ack; v.vld = vld; v.dat = dat; v.last = last; v.cnt = cnt; v.fl = fl; v.em = em;
    return v;
  endfunction

  // Expected output words for one program, honouring the zero-skip build
  task automatic queue_prog(input logic [PB-1:0] p);
    wexp_t e;
`ifdef PIM_MP_ZERO_SKIP_EN
    int last_i = -1;
    for (int i = 0; i < PWD; i++) if (word_of(p, i) != '0) last_i = i;
    for (int i = 0; i < PWD; i++) begin
      if (word_of(p, i) != '0) begin
        e.d = word_of(p, i); e.l = (i == last_i); exp_q.push_back(e);
      end
    end
`else
    for (int i = 0; i < PWD; i++) begin
      e.d = word_of(p, i); e.l = (i == PWD - 1); exp_q.push_back(e);
    end
`endif
  endtask

  // Advance one clock; any handshake about to happen is checked against the expected queue
  task automatic tick();
    if (cmd_valid && cmd_ready) begin
      n_xfer++;
      chk("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("xfer_data", cmd_data, exp_q[0].d);
        chk("xfer_last", 64'(cmd_last), 64'(exp_q[0].l));
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic push_prog(input logic [PB-1:0] p, output int cyc);
    logic ok = 1'b0;
    cyc = 0;
    mp_valid = 1'b1; mp_data = p;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mp_ack) begin ok = 1'b1; cyc = c; break; end
    end
    chk("push_ack_seen", 64'(ok), 64'd1);
    if (ok) queue_prog(p);
    mp_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string nm);
    cmd_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (count == 0 && exp_q.size() == 0) break;
      tick();
    end
    chk({nm, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_count"}, 64'(count), 64'd0);
    chk({nm, "_empty"}, 64'(empty), 64'd1);
  endtask

  initial begin
    vec_t vt[15];
    logic [PB-1:0] p1, pz, p0;
    logic [CB-1:0] w0, w1, w2, w3, prev_d;
    int cyc, got, x0;
    logic stall;

    w0 = mkw(8'h01, 32'h1000, 16'd0);
    w1 = mkw(8'h02, 32'h2000, 16'd0);
    w2 = mkw(8'h03, 32'h0000, 16'd10000);
    w3 = mkw(8'h04, 32'h3000, 16'd0);
    p1 = {w3, w2, w1, w0};
    pz = {{CB{1'b0}}, w2, {CB{1'b0}}, w0};
    p0 = '0;

    //            rst flsh mv md  rdy  ack vld dat last cnt full empty
    vt[0]  = mkv(1, 0, 0, '0, 0,  0, 0, '0, 0, 3'd0, 0, 1);
    vt[1]  = mkv(0, 0, 1, p1, 1,  1, 1, w0, 0, 3'd1, 0, 0);
    vt[2]  = mkv(0, 0, 0, p1, 1,  0, 1, w1, 0, 3'd1, 0, 0);
    vt[3]  = mkv(0, 0, 0, p1, 1,  0, 1, w2, 0, 3'd1, 0, 0);
    vt[4]  = mkv(0, 0, 0, p1, 1,  0, 1, w3, 1, 3'd1, 0, 0);
    vt[5]  = mkv(0, 0, 0, p1, 1,  0, 0, '0, 0, 3'd0, 0, 1);
    vt[6]  = mkv(0, 0, 1, p1, 0,  1, 1, w0, 0, 3'd1, 0, 0);
    for (int i = 7; i <= 11; i++)
      vt[i] = mkv(0, 0, 1, p1, 0, 0, 1, w0, 0, 3'd1, 0, 0);
    vt[12] = mkv(0, 0, 0, p1, 0,  0, 1, w0, 0, 3'd1, 0, 0);
    vt[13] = mkv(0, 1, 0, p1, 0,  0, 0, '0, 0, 3'd0, 0, 1);
    vt[14] = mkv(0, 0, 0, p1, 1,  0, 0, '0, 0, 3'd0, 0, 1);

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst; flush = vt[i].flush; mp_valid = vt[i].mv;
      mp_data = vt[i].md; cmd_ready = vt[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ack", i), 64'(mp_ack), 64'(vt[i].ack));
      chk($sformatf("v%0d_valid", i), 64'(cmd_valid), 64'(vt[i].vld));
      chk($sformatf("v%0d_last", i), 64'(cmd_last), 64'(vt[i].last));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].cnt));
      chk($sformatf("v%0d_full", i), 64'(full), 64'(vt[i].fl));
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vt[i].em));
      if (vt[i].vld) chk($sformatf("v%0d_data", i), cmd_data, vt[i].dat);
    end
    flush = 1'b0; mp_valid = 1'b0; cmd_ready = 1'b0;
    tick();

    // Fill to DEPTH with the sink stalled, then hold a fifth program until space frees
    for (int k = 0; k < DP; k++) begin
      push_prog(prog(k), cyc);
      chk("fill_ack_latency", 64'(cyc), 64'd1);
    end
    chk("fill_count", 64'(count), 64'(DP));
    chk("fill_full", 64'(full), 64'd1);
    mp_valid = 1'b1; mp_data = prog(4);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("ack_while_full", 64'(mp_ack), 64'd0);
    end
    chk("count_while_full", 64'(count), 64'(DP));
    cmd_ready = 1'b1;
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mp_ack) begin got = c; break; end
    end
    chk("ack_after_drain_cycles", 64'(got), 64'd5);
    if (got != 0) queue_prog(prog(4));
    mp_valid = 1'b0;
    drain("fill_drain");

    // Alternating ready over three entries; stalled data must hold
    cmd_ready = 1'b0;
    for (int k = 5; k < 8; k++) push_prog(prog(k), cyc);
    x0 = n_xfer;
    for (int t = 0; t < 100; t++) begin
      if (count == 0 && exp_q.size() == 0) break;
      cmd_ready = (t % 2 == 0);
      stall = cmd_valid && !cmd_ready;
      prev_d = cmd_data;
      tick();
      if (stall) chk("stall_stable", cmd_data, prev_d);
    end
    chk("toggle_words", 64'(n_xfer - x0), 64'd12);
    chk("toggle_queue_left", 64'(exp_q.size()), 64'd0);

    // Reset, then flush, in the middle of word 2 of entry 0 with two entries queued
    for (int m = 0; m < 2; m++) begin
      cmd_ready = 1'b0;
      push_prog(prog(8), cyc);
      push_prog(prog(9), cyc);
      cmd_ready = 1'b1;
      tick(); tick();
      cmd_ready = 1'b0;
      chk("mid_word2", cmd_data, word_of(prog(8), 2));
      chk("mid_count", 64'(count), 64'd2);
      if (m == 0) rst = 1'b1; else flush = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0;
      chk("clear_count", 64'(count), 64'd0);
      chk("clear_valid", 64'(cmd_valid), 64'd0);
      chk("clear_empty", 64'(empty), 64'd1);
      chk("clear_ack", 64'(mp_ack), 64'd0);
      exp_q.delete();
      push_prog(prog(10 + m), cyc);
      chk("restart_word0", cmd_data, word_of(prog(10 + m), 0));
      drain("restart_drain");
    end

    // Program with zero words, then an all-zero program
    cmd_ready = 1'b1;
    push_prog(pz, cyc);
`ifdef PIM_MP_ZERO_SKIP_EN
    chk("zero_skip_valid", 64'(cmd_valid), 64'd0);
`else
    chk("zero_word_valid", 64'(cmd_valid), 64'd1);
    chk("zero_word_data", cmd_data, 64'd0);
`endif
    drain("zero_mix_drain");
    x0 = n_xfer;
    push_prog(p0, cyc);
    drain("all_zero_drain");
`ifdef PIM_MP_ZERO_SKIP_EN
    chk("all_zero_words", 64'(n_xfer - x0), 64'd0);
`else
    chk("all_zero_words", 64'(n_xfer - x0), 64'(PWD));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
